ghost_motion_unit: RTL

Downstream stage of each per-ghost control block: the control block proposes `next_x`/`next_y`/direction every cycle from the ghost's current position, and this block decides when and whether that proposal becomes the ghost's real position. It paces movement with an internal step timer, rejects moves into walls or off-grid, feeds the committed position back to the control block, and detects capture of Pac-Man, sending the ghost home for a hold period.

---
 rtl/ghost_motion_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ghost_motion_unit.sv
// Paces a ghost's movement: samples the control block's proposal on each step tick,
// validates it against the grid and walls, commits or rejects it, and handles capture of Pac-Man.
module ghost_motion_unit #(
  parameter int         STEP_DIV  = 2500000,
  parameter int         TILE      = 20,
  parameter int         COLS      = 32,
  parameter int         ROWS      = 24,
  parameter int         X_MAX     = 620,
  parameter int         Y_MAX     = 460,
  parameter int         HOME_X    = 320,
  parameter int         HOME_Y    = 240,
  parameter int         HOME_HOLD = 8,
  parameter int         WIDTH     = 640,
  parameter int         HEIGHT    = 480,
  parameter logic [1:0] DIR_UP    = 2'd0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      freeze,
  input  logic [$clog2(WIDTH)-1:0]  next_x,
  input  logic [$clog2(HEIGHT)-1:0] next_y,
  input  logic [1:0]                next_dir,
  input  logic [ROWS*COLS-1:0]      tilemap_walls,
  input  logic [$clog2(WIDTH)-1:0]  pac_x,
  input  logic [$clog2(HEIGHT)-1:0] pac_y,
  output logic [$clog2(WIDTH)-1:0]  x,
  output logic [$clog2(HEIGHT)-1:0] y,
  output logic [1:0]                dir,
  output logic                      step_pulse,
  output logic                      blocked,
  output logic                      caught,
  output logic                      at_home
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int TW = $clog2(STEP_DIV);
  localparam int HW = $clog2(HOME_HOLD + 1);
  localparam int IW = $clog2(ROWS * COLS);

  typedef enum logic [1:0] {RUN, CHECK, HOME_WAIT} state_t;

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic [HW-1:0]   home_cnt;
  logic [XW-1:0]   reg_x, reg_col;
  logic [YW-1:0]   reg_y, reg_row;
  logic [1:0]      reg_dir;

  logic            tick, match, reject, wall_hit, in_grid;
  logic [XW-1:0]   x_rem;
  logic [YW-1:0]   y_rem;
  logic [IW-1:0]   wall_idx;

  assign tick  = (tcnt == TW'(STEP_DIV - 1)) && !freeze;
  assign match = (x == pac_x) && (y == pac_y);

  // Tile alignment is checked via the remainder left after the constant divide.
  assign x_rem    = reg_x - XW'(32'(reg_col) * TILE);
  assign y_rem    = reg_y - YW'(32'(reg_row) * TILE);
  assign in_grid  = (32'(reg_row) < ROWS) && (32'(reg_col) < COLS);
  assign wall_idx = IW'(32'(reg_row) * COLS + 32'(reg_col));
  assign wall_hit = in_grid && tilemap_walls[wall_idx];
  assign reject   = (32'(reg_x) > X_MAX) || (32'(reg_y) > Y_MAX) ||
                    (x_rem != '0) || (y_rem != '0) || wall_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      tcnt       <= '0;
      home_cnt   <= '0;
      x          <= XW'(HOME_X);
      y          <= YW'(HOME_Y);
      dir        <= DIR_UP;
      reg_x      <= '0;
      reg_y      <= '0;
      reg_col    <= '0;
      reg_row    <= '0;
      reg_dir    <= '0;
      step_pulse <= 1'b0;
      blocked    <= 1'b0;
      caught     <= 1'b0;
      at_home    <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      blocked    <= 1'b0;
      caught     <= 1'b0;

      // The timer holds during CHECK so each step spends exactly STEP_DIV RUN cycles.
      if (state != CHECK && !freeze)
        tcnt <= (tcnt == TW'(STEP_DIV - 1)) ? '0 : tcnt + 1'b1;

      case (state)
        RUN: begin
          if (match && !freeze) begin
            state    <= HOME_WAIT;
            caught   <= 1'b1;
            at_home  <= 1'b1;
            x        <= XW'(HOME_X);
            y        <= YW'(HOME_Y);
            dir      <= DIR_UP;
            home_cnt <= '0;
          end else if (tick) begin
            reg_x   <= next_x;
            reg_y   <= next_y;
            reg_dir <= next_dir;
            reg_col <= XW'(32'(next_x) / TILE);
            reg_row <= YW'(32'(next_y) / TILE);
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (reject) begin
            blocked <= 1'b1;
          end else begin
            x          <= reg_x;
            y          <= reg_y;
            dir        <= reg_dir;
            step_pulse <= 1'b1;
          end
          state <= RUN;
        end
        HOME_WAIT: begin
          x <= XW'(HOME_X);
          y <= YW'(HOME_Y);
          if (tick) begin
            if (home_cnt == HW'(HOME_HOLD - 1)) begin
              state    <= RUN;
              at_home  <= 1'b0;
              dir      <= DIR_UP;
              home_cnt <= '0;
            end else begin
              home_cnt <= home_cnt + 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
